// File: rtl/bip_dbg_pkg.sv
// Shared definitions for the BIP debug/result link: sequencer states,
// UART framing constants and the snapshot-to-byte mapping.
package bip_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  localparam int unsigned FRAME_BYTES    = 6;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        START_BIT      = 1'b0;
  localparam logic        STOP_BIT       = 1'b1;

  // Byte idx of the report frame: acc hi/lo, pc hi/lo, cyc hi/lo.
  function automatic logic [7:0] frame_byte(
    input logic [15:0] acc,
    input logic [15:0] pc,
    input logic [15:0] cyc,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = acc[15:8];
      3'd1:    b = acc[7:0];
      3'd2:    b = pc[15:8];
      3'd3:    b = pc[7:0];
      3'd4:    b = cyc[15:8];
      3'd5:    b = cyc[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter. A byte is accepted on any edge where start and
// ready are both high; ready is also raised during the final clock of the
// stop bit so consecutive bytes follow with no idle gap.
module uart_tx_byte
  import bip_dbg_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      ready,
  output logic                      bit_end,
  output logic                      tx
);

  localparam int unsigned          CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam int unsigned          FRAME_W  = UART_DATA_BITS + 2;

  logic [FRAME_W-1:0] shreg;
  logic [3:0]         bits_left;
  logic [CNT_W-1:0]   baud_cnt;

  assign bit_end = (bits_left != '0) && (baud_cnt == CNT_LAST);
  assign ready   = (bits_left == '0) || ((bits_left == 4'd1) && (baud_cnt == CNT_LAST));
  assign tx      = shreg[0];

  // Load a framed byte or shift one bit out every BAUD_DIV clocks; ones fill
  // from the top so the line idles high once the stop bit has gone out.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '1;
      bits_left <= '0;
      baud_cnt  <= '0;
    end else if (start && ready) begin
      shreg     <= {STOP_BIT, data, START_BIT};
      bits_left <= 4'(FRAME_W);
      baud_cnt  <= '0;
    end else if (bits_left != '0) begin
      if (baud_cnt == CNT_LAST) begin
        baud_cnt  <= '0;
        shreg     <= {1'b1, shreg[FRAME_W-1:1]};
        bits_left <= bits_left - 4'd1;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bip_result_tx.sv
// Host-facing BIP result readout: on the first halt rising edge, snapshots
// accumulator, PC and run-cycle count and sends them as a 6-byte UART frame.
module bip_result_tx
  import bip_dbg_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned PC_W     = 11,
  parameter int unsigned CYC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic [ACC_W-1:0] acumulador,
  input  logic [PC_W-1:0]  pc,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  state_t           state, state_next;
  logic             halt_q;
  logic [CYC_W-1:0] cyc;
  logic [ACC_W-1:0] snap_acc;
  logic [PC_W-1:0]  snap_pc;
  logic [CYC_W-1:0] snap_cyc;
  logic [2:0]       byte_idx;
  logic [2:0]       bit_cnt;
  logic             trigger;
  logic             more_bytes;
  logic             byte_start;
  logic [7:0]       byte_data;
  logic             ready;
  logic             bit_end;

  assign trigger    = (state == IDLE) && halt && !halt_q;
  assign more_bytes = byte_idx < LAST_IDX;
  assign byte_start = trigger || ((state == STOP) && ready && more_bytes);

  // Byte 0 is taken from the live inputs so the start bit leaves on the
  // trigger edge itself; later bytes come from the held snapshot.
  always_comb begin
    byte_data = 8'h00;
    if (state == IDLE)
      byte_data = frame_byte(16'(acumulador), 16'(pc), 16'(cyc), 3'd0);
    else
      byte_data = frame_byte(16'(snap_acc), 16'(snap_pc), 16'(snap_cyc), byte_idx + 3'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: follows the transmitter through start, data and stop bits.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_cnt == LAST_BIT)) state_next = STOP;
      STOP:    if (ready) state_next = more_bytes ? START : DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == START) || (state == DATA) || (state == STOP);
    done = (state == DONE);
  end

  // Halt edge detector and saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
      cyc    <= '0;
    end else begin
      halt_q <= halt;
      if ((state == IDLE) && !halt && (cyc != '1))
        cyc <= cyc + CYC_W'(1);
    end
  end

  // Snapshot capture, byte index and data-bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_acc <= '0;
      snap_pc  <= '0;
      snap_cyc <= '0;
      byte_idx <= '0;
      bit_cnt  <= '0;
    end else begin
      if (trigger) begin
        snap_acc <= acumulador;
        snap_pc  <= pc;
        snap_cyc <= cyc;
        byte_idx <= '0;
      end else if ((state == STOP) && ready && more_bytes) begin
        byte_idx <= byte_idx + 3'd1;
      end
      if (state == START)
        bit_cnt <= '0;
      else if ((state == DATA) && bit_end)
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (byte_start),
    .data    (byte_data),
    .ready   (ready),
    .bit_end (bit_end),
    .tx      (tx)
  );

endmodule
